mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, meaning the number of consecutive dmem grants allowed while imem waits; legal range 1..15.
REQ-002 Port: clk  in  1  sole clock, rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-high.
REQ-004 Port: imem_addr  in  32  CPU fetch address.
REQ-005 Port: imem_rmask  in  4  CPU fetch mask; nonzero means a fetch request.
REQ-006 Port: imem_rdata  out  32  fetch data.
REQ-007 Port: imem_resp  out  1  fetch-done pulse.
REQ-008 Port: dmem_addr  in  32  CPU data address.
REQ-009 Port: dmem_rmask  in  4  CPU load mask.
REQ-010 Port: dmem_wmask  in  4  CPU store mask.
REQ-011 Port: dmem_wdata  in  32  CPU store data.
REQ-012 Port: dmem_rdata  out  32  load data.
REQ-013 Port: dmem_resp  out  1  data-done pulse.
REQ-014 Port: mem_addr  out  32  downstream address, word-aligned as received.
REQ-015 Port: mem_read  out  1  downstream read request.
REQ-016 Port: mem_write  out  1  downstream write request.
REQ-017 Port: mem_wmask  out  4  downstream byte-write mask.
REQ-018 Port: mem_wdata  out  32  downstream write data.
REQ-019 Port: mem_rdata  in  32  downstream read data, valid when mem_resp=1.
REQ-020 Port: mem_resp  in  1  downstream completion, one-cycle pulse.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-022 Request detection: the imem request is (imem_rmask!=0); the dmem request is (dmem_rmask!=0 | dmem_wmask!=0); both are sampled only in IDLE.
REQ-023 Request holding: the upstream side holds addr, masks and wdata stable until its resp pulse, and changes or drops the request in the cycle after resp.
REQ-024 Grant rule: in IDLE with both requests pending, dmem SHALL win unless starve_cnt==STARVE_LIMIT, in which case imem wins.
REQ-025 Starvation counter: starve_cnt SHALL increment (saturating) on each dmem grant with imem pending, and SHALL clear on any imem grant or when imem is not pending at a grant.
REQ-026 Grant transfer: on a grant, the arbiter SHALL register addr, wmask and wdata, set mem_read or mem_write, record the owner, and move to BUSY.
REQ-027 Request lines in BUSY: mem_read and mem_write SHALL be registered and SHALL stay constant throughout BUSY.
REQ-028 Read/write select: a dmem request with nonzero wmask SHALL issue mem_write regardless of rmask; all other requests SHALL issue mem_read with mem_wmask=0.
REQ-029 BUSY completion: mem_resp SHALL move the FSM to DONE, deassert mem_read/mem_write at that edge, and latch mem_rdata into the owner's rdata register (reads only).
REQ-030 DONE: the owner's resp SHALL be high for exactly this one cycle, no grant is made, and the next state is IDLE.
REQ-031 Latency: with a zero-wait memory (mem_resp in the first BUSY cycle), the request seen at cycle 0 SHALL produce mem_read/mem_write in cycle 1 and resp in cycle 2.
REQ-032 imem_rdata and dmem_rdata SHALL hold their last latched values between responses; a write SHALL NOT alter dmem_rdata.
REQ-033 mem_resp received in IDLE or DONE SHALL be ignored.
REQ-034 At most one downstream transaction SHALL be outstanding at any time.

Reset
REQ-035 rst SHALL asynchronously force IDLE, starve_cnt=0, mem_read=mem_write=0, imem_resp=dmem_resp=0, and clear mem_addr, mem_wmask, mem_wdata, imem_rdata and dmem_rdata.
REQ-036 Reset mid-BUSY SHALL abandon the transaction with no resp pulse; a late mem_resp after reset SHALL be ignored per REQ-033.

Structure
REQ-037 The state enum arb_state_t {IDLE, BUSY, DONE} and the owner enum arb_owner_t {OWN_IMEM, OWN_DMEM} SHALL live in rv32imc_types.
REQ-038 The grant selection and starve counter SHALL be one sub-module, mem_arb_prio; the FSM and datapath registers SHALL stay in mem_arbiter.

Verification
REQ-039 Single fetch: imem_addr=0x60000000, rmask=0xF; mem_resp in the first BUSY cycle with rdata=0x00000013 -> mem_read in cycle 1, imem_resp=1 with imem_rdata=0x00000013 in cycle 2, IDLE in cycle 3.
REQ-040 Store: dmem_addr=0x60001004, wmask=0x3, wdata=0xDEADBEEF -> mem_write=1, mem_wmask=0x3, mem_wdata=0xDEADBEEF; dmem_resp pulses once; dmem_rdata unchanged.
REQ-041 Contention: imem and dmem requesting together in IDLE -> dmem served first, then imem; two resp pulses, never simultaneous.
REQ-042 Starvation: imem held continuously while dmem re-requests after every resp, STARVE_LIMIT=4 -> exactly 4 dmem grants, then an imem grant, then starve_cnt=0.
REQ-043 Reset mid-BUSY: rst asserted with mem_read=1 -> mem_read drops without a clock edge; a mem_resp one cycle later produces no resp.
REQ-044 Wait states: mem_resp delayed by 5 cycles -> mem_addr and mem_read stable for all BUSY cycles and resp exactly one cycle after mem_resp.

Source files
------------

// File: rtl/rv32imc_types.sv
// Shared type definitions for the memory arbiter slice.
package rv32imc_types;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } arb_state_t;

   typedef enum logic {
      OWN_IMEM,
      OWN_DMEM
   } arb_owner_t;

   localparam int unsigned STARVE_CNT_W = 4;

   // A data request carrying any byte-write enable is a store, whatever its rmask.
   function automatic logic is_store(input logic [3:0] wmask);
      return wmask != 4'h0;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data ports, with a saturating starvation
// counter that lets imem through after STARVE_LIMIT back-to-back dmem wins.
module mem_arb_prio
   import rv32imc_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en,
   input  logic imem_req,
   input  logic dmem_req,
   output logic grant_imem,
   output logic grant_dmem
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic                    imem_wins;

   always_comb begin
      imem_wins  = imem_req && (!dmem_req || (starve_cnt == LIMIT));
      grant_imem = arb_en && imem_wins;
      grant_dmem = arb_en && dmem_req && !imem_wins;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (arb_en && (imem_req || dmem_req)) begin
         if (grant_dmem && imem_req)
            starve_cnt <= (starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1;
         else
            starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single downstream memory port with
// one transaction outstanding; IDLE grants, BUSY waits for mem_resp, DONE pulses resp.
module mem_arbiter
   import rv32imc_types::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   arb_state_t state;
   arb_owner_t owner;
   logic       imem_req;
   logic       dmem_req;
   logic       grant_imem;
   logic       grant_dmem;

   always_comb begin
      imem_req = imem_rmask != 4'h0;
      dmem_req = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
   end

   mem_arb_prio #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_prio (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (state == IDLE),
      .imem_req  (imem_req),
      .dmem_req  (dmem_req),
      .grant_imem(grant_imem),
      .grant_dmem(grant_dmem)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_IMEM;
         mem_addr   <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_wmask  <= '0;
         mem_wdata  <= '0;
         imem_rdata <= '0;
         dmem_rdata <= '0;
         imem_resp  <= 1'b0;
         dmem_resp  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               imem_resp <= 1'b0;
               dmem_resp <= 1'b0;
               if (grant_imem) begin
                  owner     <= OWN_IMEM;
                  mem_addr  <= imem_addr;
                  mem_wmask <= '0;
                  mem_wdata <= '0;
                  mem_read  <= 1'b1;
                  mem_write <= 1'b0;
                  state     <= BUSY;
               end else if (grant_dmem) begin
                  owner     <= OWN_DMEM;
                  mem_addr  <= dmem_addr;
                  mem_wdata <= dmem_wdata;
                  if (is_store(dmem_wmask)) begin
                     mem_wmask <= dmem_wmask;
                     mem_read  <= 1'b0;
                     mem_write <= 1'b1;
                  end else begin
                     mem_wmask <= '0;
                     mem_read  <= 1'b1;
                     mem_write <= 1'b0;
                  end
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  state     <= DONE;
                  if (owner == OWN_IMEM) begin
                     imem_rdata <= mem_rdata;
                     imem_resp  <= 1'b1;
                  end else begin
                     // mem_read is still the registered request of this transaction
                     if (mem_read)
                        dmem_rdata <= mem_rdata;
                     dmem_resp <= 1'b1;
                  end
               end
            end
            DONE: begin
               imem_resp <= 1'b0;
               dmem_resp <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               imem_resp <= 1'b0;
               dmem_resp <= 1'b0;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;
   import rv32imc_types::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int unsigned passed;
   int unsigned total;

   mem_arbiter #(
      .STARVE_LIMIT(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .imem_addr (imem_addr),
      .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata),
      .imem_resp (imem_resp),
      .dmem_addr (dmem_addr),
      .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask),
      .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .dmem_resp (dmem_resp),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic serve(input logic [31:0] rd);
      mem_resp  = 1'b1;
      mem_rdata = rd;
      tick();
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      imem_addr = '0; imem_rmask = '0;
      dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      repeat (2) tick();
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL reset_req read=%b write=%b want 0 0", mem_read, mem_write); else passed++;
      total++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0) $display("FAIL reset_resp i=%b d=%b want 0 0", imem_resp, dmem_resp); else passed++;
      total++; if (mem_addr !== 32'h0 || mem_wmask !== 4'h0 || mem_wdata !== 32'h0) $display("FAIL reset_dp addr=%h wm=%h wd=%h want 0", mem_addr, mem_wmask, mem_wdata); else passed++;
      total++; if (imem_rdata !== 32'h0 || dmem_rdata !== 32'h0) $display("FAIL reset_rdata i=%h d=%h want 0", imem_rdata, dmem_rdata); else passed++;
      total++; if (dut.state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dut.state); else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch();
      imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
      tick();
      total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) $display("FAIL fetch_c1_req read=%b write=%b want 1 0", mem_read, mem_write); else passed++;
      total++; if (mem_addr !== 32'h6000_0000 || mem_wmask !== 4'h0) $display("FAIL fetch_c1_addr addr=%h wm=%h want 60000000 0", mem_addr, mem_wmask); else passed++;
      serve(32'h0000_0013);
      total++; if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_0013) $display("FAIL fetch_c2_resp resp=%b rdata=%h want 1 00000013", imem_resp, imem_rdata); else passed++;
      total++; if (mem_read !== 1'b0 || dmem_resp !== 1'b0) $display("FAIL fetch_c2_idle read=%b dresp=%b want 0 0", mem_read, dmem_resp); else passed++;
      imem_rmask = 4'h0;
      tick();
      total++; if (imem_resp !== 1'b0 || dut.state !== IDLE) $display("FAIL fetch_c3 resp=%b state=%0d want 0 IDLE", imem_resp, dut.state); else passed++;
   endtask

   task automatic test_load();
      dmem_addr = 32'h6000_0100; dmem_rmask = 4'hF;
      tick();
      total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h6000_0100) $display("FAIL load_req read=%b write=%b addr=%h want 1 0 60000100", mem_read, mem_write, mem_addr); else passed++;
      serve(32'hCAFE_F00D);
      total++; if (dmem_resp !== 1'b1 || dmem_rdata !== 32'hCAFE_F00D || imem_resp !== 1'b0) $display("FAIL load_resp resp=%b rdata=%h iresp=%b want 1 cafef00d 0", dmem_resp, dmem_rdata, imem_resp); else passed++;
      dmem_rmask = 4'h0;
      tick();
   endtask

   task automatic test_store();
      // rmask also set: a nonzero wmask must still make this a write
      dmem_addr = 32'h6000_1004; dmem_rmask = 4'hF; dmem_wmask = 4'h3; dmem_wdata = 32'hDEAD_BEEF;
      tick();
      total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL store_req write=%b read=%b want 1 0", mem_write, mem_read); else passed++;
      total++; if (mem_addr !== 32'h6000_1004 || mem_wmask !== 4'h3 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL store_dp addr=%h wm=%h wd=%h want 60001004 3 deadbeef", mem_addr, mem_wmask, mem_wdata); else passed++;
      tick();
      total++; if (mem_write !== 1'b1 || mem_addr !== 32'h6000_1004 || dmem_resp !== 1'b0) $display("FAIL store_hold write=%b addr=%h resp=%b want 1 60001004 0", mem_write, mem_addr, dmem_resp); else passed++;
      serve(32'h1111_1111);
      total++; if (dmem_resp !== 1'b1 || mem_write !== 1'b0) $display("FAIL store_resp resp=%b write=%b want 1 0", dmem_resp, mem_write); else passed++;
      total++; if (dmem_rdata !== 32'hCAFE_F00D) $display("FAIL store_rdata got %h want cafef00d", dmem_rdata); else passed++;
      dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = '0;
      tick();
      total++; if (dmem_resp !== 1'b0) $display("FAIL store_pulse resp=%b want 0", dmem_resp); else passed++;
   endtask

   task automatic test_contention();
      imem_addr = 32'h6000_0040; imem_rmask = 4'hF;
      dmem_addr = 32'h6000_2000; dmem_rmask = 4'hF;
      tick();
      total++; if (mem_addr !== 32'h6000_2000 || mem_read !== 1'b1) $display("FAIL cont_first addr=%h read=%b want 60002000 1", mem_addr, mem_read); else passed++;
      serve(32'h0BAD_0001);
      total++; if (dmem_resp !== 1'b1 || imem_resp !== 1'b0) $display("FAIL cont_resp1 d=%b i=%b want 1 0", dmem_resp, imem_resp); else passed++;
      dmem_rmask = 4'h0;
      tick();
      tick();
      total++; if (mem_addr !== 32'h6000_0040 || mem_read !== 1'b1) $display("FAIL cont_second addr=%h read=%b want 60000040 1", mem_addr, mem_read); else passed++;
      serve(32'h0BAD_0002);
      total++; if (imem_resp !== 1'b1 || dmem_resp !== 1'b0 || imem_rdata !== 32'h0BAD_0002) $display("FAIL cont_resp2 i=%b d=%b rd=%h want 1 0 0bad0002", imem_resp, dmem_resp, imem_rdata); else passed++;
      imem_rmask = 4'h0;
      tick();
   endtask

   task automatic test_starvation();
      logic [31:0] exp_addr;
      logic [3:0]  exp_cnt;
      imem_addr = 32'h6000_0200; imem_rmask = 4'hF;
      dmem_addr = 32'h6000_0300; dmem_rmask = 4'hF;
      for (int k = 0; k < 5; k++) begin
         exp_addr = (k < 4) ? 32'h6000_0300 : 32'h6000_0200;
         exp_cnt  = (k < 4) ? 4'(k + 1) : 4'h0;
         tick();
         total++; if (mem_addr !== exp_addr) $display("FAIL starve_grant%0d addr=%h want %h", k, mem_addr, exp_addr); else passed++;
         total++; if (dut.u_prio.starve_cnt !== exp_cnt) $display("FAIL starve_cnt%0d got %0d want %0d", k, dut.u_prio.starve_cnt, exp_cnt); else passed++;
         serve(32'h5000_0000 + 32'(k));
         total++; if (dmem_resp !== (k < 4) || imem_resp !== (k == 4)) $display("FAIL starve_resp%0d d=%b i=%b want %b %b", k, dmem_resp, imem_resp, (k < 4), (k == 4)); else passed++;
         if (k == 4) begin
            imem_rmask = 4'h0;
            dmem_rmask = 4'h0;
         end
         tick();
      end
   endtask

   task automatic test_wait_states();
      imem_addr = 32'h6000_0080; imem_rmask = 4'hF;
      tick();
      for (int w = 0; w < 5; w++) begin
         total++; if (mem_read !== 1'b1 || mem_addr !== 32'h6000_0080 || imem_resp !== 1'b0) $display("FAIL wait_busy%0d read=%b addr=%h resp=%b want 1 60000080 0", w, mem_read, mem_addr, imem_resp); else passed++;
         tick();
      end
      serve(32'hA5A5_0001);
      total++; if (imem_resp !== 1'b1 || imem_rdata !== 32'hA5A5_0001) $display("FAIL wait_resp resp=%b rd=%h want 1 a5a50001", imem_resp, imem_rdata); else passed++;
      imem_rmask = 4'h0;
      tick();
   endtask

   task automatic test_stray_resp();
      mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_resp = 1'b0; mem_rdata = '0;
      tick();
      total++; if (imem_resp !== 1'b0 || dmem_resp !== 1'b0 || imem_rdata !== 32'hA5A5_0001) $display("FAIL stray_resp i=%b d=%b ird=%h want 0 0 a5a50001", imem_resp, dmem_resp, imem_rdata); else passed++;
      total++; if (dut.state !== IDLE || mem_read !== 1'b0) $display("FAIL stray_state state=%0d read=%b want IDLE 0", dut.state, mem_read); else passed++;
   endtask

   task automatic test_reset_mid_busy();
      dmem_addr = 32'h6000_0400; dmem_rmask = 4'hF;
      tick();
      total++; if (mem_read !== 1'b1) $display("FAIL rstbusy_pre read=%b want 1", mem_read); else passed++;
      #2;
      rst = 1'b1;
      dmem_rmask = 4'h0;
      #1;
      total++; if (mem_read !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rstbusy_async read=%b addr=%h want 0 0", mem_read, mem_addr); else passed++;
      #1;
      rst = 1'b0;
      tick();
      serve(32'h7777_7777);
      total++; if (dmem_resp !== 1'b0 || imem_resp !== 1'b0) $display("FAIL rstbusy_late d=%b i=%b want 0 0", dmem_resp, imem_resp); else passed++;
      total++; if (dmem_rdata !== 32'h0 || dut.state !== IDLE) $display("FAIL rstbusy_clean rd=%h state=%0d want 0 IDLE", dmem_rdata, dut.state); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_contention();
      test_starvation();
      test_wait_states();
      test_stray_resp();
      test_reset_mid_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
